// File: rtl/ram_pll_bist.sv
// RAM self-test that runs once the PLL reports stable lock: it writes a seeded pattern, reads it back and compares.
// Latency: 1 cycle from READ issue to compare; an iteration takes 2*(2*2^ADDR_W+1) cycles.
// Backpressure: none. Losing lock aborts the test and restarts lock qualification.
module ram_pll_bist #(
  parameter int          ADDR_W      = 8,
  parameter int          DATA_W      = 8,
  parameter int          LOCK_CYCLES = 1024,
  parameter int unsigned SEED        = 32'hA5
) (
  input  logic              clk,
  input  logic              rst,
  input  logic              locked,
  input  logic              inj_err,
  output logic [7:0]        led_o,
  output logic              fail,
  output logic [7:0]        err_cnt,
  output logic [ADDR_W-1:0] first_err_addr,
  output logic [15:0]       iter_cnt
);

  localparam int LOCK_W = (LOCK_CYCLES > 1) ? $clog2(LOCK_CYCLES) : 1;
  localparam logic [LOCK_W-1:0] LOCK_LAST = LOCK_W'(LOCK_CYCLES - 1);
  localparam logic [ADDR_W-1:0] ADDR_LAST = '1;

  localparam logic [1:0] S_WAIT_LOCK = 2'd0;
  localparam logic [1:0] S_WRITE     = 2'd1;
  localparam logic [1:0] S_READ      = 2'd2;
  localparam logic [1:0] S_DRAIN     = 2'd3;

  logic [1:0]        state_q, state_d;
  logic [LOCK_W-1:0] lock_cnt_q, lock_cnt_d;
  logic [ADDR_W-1:0] addr_q, addr_d;
  logic              pass_q, pass_d;
  logic              cmp_vld_q, cmp_vld_d;
  logic [DATA_W-1:0] cmp_exp_q, cmp_exp_d;
  logic [ADDR_W-1:0] cmp_addr_q, cmp_addr_d;
  logic              fail_q, fail_d;
  logic [7:0]        err_cnt_q, err_cnt_d;
  logic [ADDR_W-1:0] first_q, first_d;
  logic [15:0]       iter_q, iter_d;

  logic [DATA_W-1:0] mem [2**ADDR_W];
  logic [DATA_W-1:0] rdata_q;
  logic              ram_we;
  logic [DATA_W-1:0] pat_word;
  logic [DATA_W-1:0] exp_word;
  logic [DATA_W-1:0] wdata;
  logic              mismatch;

  // Pass 1 stores the complement so every bit is exercised at both polarities.
  assign pat_word = DATA_W'(addr_q) ^ DATA_W'(SEED);
  assign exp_word = pass_q ? ~pat_word : pat_word;
  assign wdata    = exp_word ^ {{(DATA_W-1){1'b0}}, inj_err};

  // A compare only counts while lock holds; a lock drop throws the in-flight compare away.
  assign mismatch = cmp_vld_q && locked && (rdata_q != cmp_exp_q);

  // Single-port RAM with a registered read; contents are deliberately not reset.
  always_ff @(posedge clk) begin
    if (ram_we) mem[addr_q] <= wdata;
    rdata_q <= mem[addr_q];
  end

  // Next-state logic: lock qualification, write/read sweeps, error bookkeeping.
  always_comb begin
    state_d    = state_q;
    lock_cnt_d = lock_cnt_q;
    addr_d     = addr_q;
    pass_d     = pass_q;
    cmp_vld_d  = 1'b0;
    cmp_exp_d  = cmp_exp_q;
    cmp_addr_d = cmp_addr_q;
    fail_d     = fail_q;
    err_cnt_d  = err_cnt_q;
    first_d    = first_q;
    iter_d     = iter_q;
    ram_we     = 1'b0;

    if (mismatch) begin
      fail_d = 1'b1;
      if (err_cnt_q != 8'hFF) err_cnt_d = err_cnt_q + 8'd1;
      if (err_cnt_q == 8'h00) first_d = cmp_addr_q;
    end

    if (state_q == S_WAIT_LOCK) begin
      if (!locked) begin
        lock_cnt_d = '0;
      end else if (lock_cnt_q == LOCK_LAST) begin
        lock_cnt_d = '0;
        addr_d     = '0;
        state_d    = S_WRITE;
      end else begin
        lock_cnt_d = lock_cnt_q + LOCK_W'(1);
      end
    end else if (!locked) begin
      state_d    = S_WAIT_LOCK;
      lock_cnt_d = '0;
      addr_d     = '0;
      pass_d     = 1'b0;
      cmp_vld_d  = 1'b0;
    end else begin
      case (state_q)
        S_WRITE: begin
          ram_we = 1'b1;
          addr_d = addr_q + ADDR_W'(1);
          if (addr_q == ADDR_LAST) state_d = S_READ;
        end
        S_READ: begin
          cmp_vld_d  = 1'b1;
          cmp_exp_d  = exp_word;
          cmp_addr_d = addr_q;
          addr_d     = addr_q + ADDR_W'(1);
          if (addr_q == ADDR_LAST) state_d = S_DRAIN;
        end
        default: begin
          // DRAIN: last compare happens above; then start the next pass.
          addr_d  = '0;
          state_d = S_WRITE;
          if (pass_q) begin
            pass_d = 1'b0;
            iter_d = iter_q + 16'd1;
          end else begin
            pass_d = 1'b1;
          end
        end
      endcase
    end
  end

  // State registers with asynchronous reset.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state_q    <= S_WAIT_LOCK;
      lock_cnt_q <= '0;
      addr_q     <= '0;
      pass_q     <= 1'b0;
      cmp_vld_q  <= 1'b0;
      cmp_exp_q  <= '0;
      cmp_addr_q <= '0;
      fail_q     <= 1'b0;
      err_cnt_q  <= '0;
      first_q    <= '0;
      iter_q     <= '0;
    end else begin
      state_q    <= state_d;
      lock_cnt_q <= lock_cnt_d;
      addr_q     <= addr_d;
      pass_q     <= pass_d;
      cmp_vld_q  <= cmp_vld_d;
      cmp_exp_q  <= cmp_exp_d;
      cmp_addr_q <= cmp_addr_d;
      fail_q     <= fail_d;
      err_cnt_q  <= err_cnt_d;
      first_q    <= first_d;
      iter_q     <= iter_d;
    end
  end

  assign led_o          = {fail_q, (state_q != S_WAIT_LOCK), iter_q[5:0]};
  assign fail           = fail_q;
  assign err_cnt        = err_cnt_q;
  assign first_err_addr = first_q;
  assign iter_cnt       = iter_q;

endmodule

// File: tb/tb_ram_pll_bist.sv
// Bench for ram_pll_bist with ADDR_W=2, LOCK_CYCLES=4, SEED=8'hA5.
// Vectors hold inputs for N cycles, then check the outputs; expectations go through a queue.
// Ends with a hand-written asynchronous reset asserted between clock edges.
module tb_ram_pll_bist;

  logic        clk = 1'b0;
  logic        rst;
  logic        locked;
  logic        inj_err;
  logic [7:0]  led_o;
  logic        fail;
  logic [7:0]  err_cnt;
  logic [1:0]  first_err_addr;
  logic [15:0] iter_cnt;

  int errors = 0;
  int checks = 0;

  typedef struct {
    logic        rst;
    logic        locked;
    logic        inj;
    int          ncyc;
    logic [7:0]  led;
    logic        fail;
    logic [7:0]  err;
    logic [1:0]  first;
    logic [15:0] iter;
  } vec_t;

  vec_t vecs[$];
  vec_t sb[$];

  ram_pll_bist #(
    .ADDR_W(2), .DATA_W(8), .LOCK_CYCLES(4), .SEED(32'hA5)
  ) dut (
    .clk(clk), .rst(rst), .locked(locked), .inj_err(inj_err),
    .led_o(led_o), .fail(fail), .err_cnt(err_cnt),
    .first_err_addr(first_err_addr), .iter_cnt(iter_cnt)
  );

  always #5 clk = ~clk;

  task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got %0h expected %0h", nm, act, exp);
    end
  endtask

  task automatic add(input logic r, input logic l, input logic i, input int n,
                     input logic [7:0] led, input logic f, input logic [7:0] e,
                     input logic [1:0] fa, input logic [15:0] it);
    vec_t v;
    v.rst = r; v.locked = l; v.inj = i; v.ncyc = n;
    v.led = led; v.fail = f; v.err = e; v.first = fa; v.iter = it;
    vecs.push_back(v);
  endtask

  initial begin
    vec_t e;
    rst = 1'b1; locked = 1'b1; inj_err = 1'b0;

    // Clean run: busy after 4 locked cycles, one iteration 18 cycles later.
    add(1, 1, 0,  2, 8'h00, 0, 8'd0, 2'd0, 16'd0);
    add(0, 1, 0,  3, 8'h00, 0, 8'd0, 2'd0, 16'd0);
    add(0, 1, 0,  1, 8'h40, 0, 8'd0, 2'd0, 16'd0);
    add(0, 1, 0, 17, 8'h40, 0, 8'd0, 2'd0, 16'd0);
    add(0, 1, 0,  1, 8'h41, 0, 8'd0, 2'd0, 16'd1);
    // Lock glitch during qualification restarts the count.
    add(1, 1, 0,  2, 8'h00, 0, 8'd0, 2'd0, 16'd0);
    add(0, 1, 0,  2, 8'h00, 0, 8'd0, 2'd0, 16'd0);
    add(0, 0, 0,  1, 8'h00, 0, 8'd0, 2'd0, 16'd0);
    add(0, 1, 0,  3, 8'h00, 0, 8'd0, 2'd0, 16'd0);
    add(0, 1, 0,  1, 8'h40, 0, 8'd0, 2'd0, 16'd0);
    // Lock loss mid-READ at addr 1 of the second iteration; restart at pass 0.
    add(1, 1, 0,  2, 8'h00, 0, 8'd0, 2'd0, 16'd0);
    add(0, 1, 0, 22, 8'h41, 0, 8'd0, 2'd0, 16'd1);
    add(0, 1, 0,  5, 8'h41, 0, 8'd0, 2'd0, 16'd1);
    add(0, 0, 0,  1, 8'h01, 0, 8'd0, 2'd0, 16'd1);
    add(0, 1, 0,  3, 8'h01, 0, 8'd0, 2'd0, 16'd1);
    add(0, 1, 0,  1, 8'h41, 0, 8'd0, 2'd0, 16'd1);
    add(0, 1, 0,  9, 8'h41, 0, 8'd0, 2'd0, 16'd1);
    add(0, 1, 0,  9, 8'h42, 0, 8'd0, 2'd0, 16'd2);
    // Continuous injection: 8 errors per iteration, saturating at 255.
    add(1, 1, 1,  2, 8'h00, 0, 8'd0, 2'd0, 16'd0);
    add(0, 1, 1, 10, 8'hC0, 1, 8'd1, 2'd0, 16'd0);
    add(0, 1, 1, 12, 8'hC1, 1, 8'd8, 2'd0, 16'd1);
    add(0, 1, 1, 1242, 8'hC6, 1, 8'd255, 2'd0, 16'd70);
    // Single injected fault on addr 2, pass 0: A6 read back vs A7 expected.
    add(1, 1, 0,  2, 8'h00, 0, 8'd0, 2'd0, 16'd0);
    add(0, 1, 0,  6, 8'h40, 0, 8'd0, 2'd0, 16'd0);
    add(0, 1, 1,  1, 8'h40, 0, 8'd0, 2'd0, 16'd0);
    add(0, 1, 0,  4, 8'h40, 0, 8'd0, 2'd0, 16'd0);
    add(0, 1, 0,  1, 8'hC0, 1, 8'd1, 2'd2, 16'd0);
    add(0, 1, 0, 10, 8'hC1, 1, 8'd1, 2'd2, 16'd1);
    add(0, 1, 0, 18, 8'hC2, 1, 8'd1, 2'd2, 16'd2);

    for (int i = 0; i < vecs.size(); i++) begin
      rst     = vecs[i].rst;
      locked  = vecs[i].locked;
      inj_err = vecs[i].inj;
      sb.push_back(vecs[i]);
      repeat (vecs[i].ncyc) @(negedge clk);
      e = sb.pop_front();
      chk($sformatf("v%0d led_o", i),    32'(led_o),          32'(e.led));
      chk($sformatf("v%0d fail", i),     32'(fail),           32'(e.fail));
      chk($sformatf("v%0d err_cnt", i),  32'(err_cnt),        32'(e.err));
      chk($sformatf("v%0d first", i),    32'(first_err_addr), 32'(e.first));
      chk($sformatf("v%0d iter_cnt", i), 32'(iter_cnt),       32'(e.iter));
    end

    // Async reset mid-WRITE: outputs must clear before the next clock edge.
    repeat (2) @(negedge clk);
    chk("pre-rst led_o", 32'(led_o), 32'h00C2);
    #2 rst = 1'b1;
    #1;
    chk("async led_o",    32'(led_o),          32'h0);
    chk("async fail",     32'(fail),           32'h0);
    chk("async err_cnt",  32'(err_cnt),        32'h0);
    chk("async first",    32'(first_err_addr), 32'h0);
    chk("async iter_cnt", 32'(iter_cnt),       32'h0);
    @(negedge clk);
    rst = 1'b0;
    repeat (4) @(negedge clk);
    chk("post-rst busy", 32'(led_o), 32'h0040);

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
